// File: rtl/trap_ctrl.sv
// Trap/return sequencer: turns committed ecall, mret and enabled timer interrupts into
// mepc/mcause/mstatus write pulses followed by a held IFU redirect request.
module trap_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IRQ_CAUSE = 7
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_commit_valid,
  input  logic [XLEN-1:0] i_commit_pc,
  input  logic [XLEN-1:0] i_commit_npc,
  input  logic            i_ecall,
  input  logic            i_mret,
  input  logic            i_irq,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_mepc_wen,
  output logic [XLEN-1:0] o_mepc_wdata,
  output logic            o_mcause_wen,
  output logic [XLEN-1:0] o_mcause_wdata,
  output logic            o_mstatus_wen,
  output logic [XLEN-1:0] o_mstatus_wdata,
  output logic            o_redir_valid,
  output logic [XLEN-1:0] o_redir_pc,
  input  logic            i_redir_ready,
  output logic            o_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRAP_SAVE = 3'd1,
    TRAP_STAT = 3'd2,
    RET_STAT  = 3'd3,
    REDIR     = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] ECALL_MCAUSE = XLEN'(11);
  localparam logic [XLEN-1:0] IRQ_MCAUSE   = {1'b1, (XLEN-1)'(IRQ_CAUSE)};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            is_irq_q, is_irq_d;

  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] ret_mstatus;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] trap_target;

  // mstatus images for trap entry (stack MIE into MPIE) and mret (restore MIE from MPIE)
  always_comb begin
    trap_mstatus        = i_mstatus;
    trap_mstatus[7]     = i_mstatus[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;

    ret_mstatus         = i_mstatus;
    ret_mstatus[3]      = i_mstatus[7];
    ret_mstatus[7]      = 1'b1;
    ret_mstatus[12:11]  = 2'b11;
  end

  // Vectored mode only offsets interrupts; the offset is cause<<2 truncated to XLEN.
  always_comb begin
    vec_base = {i_mtvec[XLEN-1:2], 2'b00};
    vec_off  = {cause_q[XLEN-4:0], 2'b00};
    if (i_mtvec[1:0] == 2'b01 && is_irq_q) begin
      trap_target = vec_base + vec_off;
    end else begin
      trap_target = vec_base;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cause_d         = cause_q;
    target_d        = target_q;
    is_irq_d        = is_irq_q;
    o_mepc_wen      = 1'b0;
    o_mepc_wdata    = '0;
    o_mcause_wen    = 1'b0;
    o_mcause_wdata  = '0;
    o_mstatus_wen   = 1'b0;
    o_mstatus_wdata = '0;
    o_redir_valid   = 1'b0;
    o_redir_pc      = '0;

    unique case (state_q)
      IDLE: begin
        if (i_commit_valid) begin
          if (i_ecall) begin
            pc_d     = i_commit_pc;
            cause_d  = ECALL_MCAUSE;
            is_irq_d = 1'b0;
            state_d  = TRAP_SAVE;
          end else if (i_mret) begin
            state_d  = RET_STAT;
          end else if (i_irq && i_mstatus[3]) begin
            pc_d     = i_commit_npc;
            cause_d  = IRQ_MCAUSE;
            is_irq_d = 1'b1;
            state_d  = TRAP_SAVE;
          end
        end
      end
      TRAP_SAVE: begin
        o_mepc_wen     = 1'b1;
        o_mepc_wdata   = pc_q;
        o_mcause_wen   = 1'b1;
        o_mcause_wdata = cause_q;
        state_d        = TRAP_STAT;
      end
      TRAP_STAT: begin
        o_mstatus_wen   = 1'b1;
        o_mstatus_wdata = trap_mstatus;
        target_d        = trap_target;
        state_d         = REDIR;
      end
      RET_STAT: begin
        o_mstatus_wen   = 1'b1;
        o_mstatus_wdata = ret_mstatus;
        target_d        = i_mepc;
        state_d         = REDIR;
      end
      REDIR: begin
        o_redir_valid = 1'b1;
        o_redir_pc    = target_q;
        if (i_redir_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
      is_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      is_irq_q <= is_irq_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Closed-loop bench for trap_ctrl: the bench plays the CSR file and IFU and predicts each
// cycle's outputs from a queue of architectural effects scheduled at commit time.
module tb_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_commit_valid;
  logic [31:0] i_commit_pc, i_commit_npc;
  logic        i_ecall, i_mret, i_irq;
  logic [31:0] i_mtvec, i_mstatus, i_mepc;
  logic        o_mepc_wen, o_mcause_wen, o_mstatus_wen, o_redir_valid, o_busy;
  logic [31:0] o_mepc_wdata, o_mcause_wdata, o_mstatus_wdata, o_redir_pc;
  logic        i_redir_ready;

  trap_ctrl #(.XLEN(32), .IRQ_CAUSE(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_commit_valid(i_commit_valid), .i_commit_pc(i_commit_pc), .i_commit_npc(i_commit_npc),
    .i_ecall(i_ecall), .i_mret(i_mret), .i_irq(i_irq),
    .i_mtvec(i_mtvec), .i_mstatus(i_mstatus), .i_mepc(i_mepc),
    .o_mepc_wen(o_mepc_wen), .o_mepc_wdata(o_mepc_wdata),
    .o_mcause_wen(o_mcause_wen), .o_mcause_wdata(o_mcause_wdata),
    .o_mstatus_wen(o_mstatus_wen), .o_mstatus_wdata(o_mstatus_wdata),
    .o_redir_valid(o_redir_valid), .o_redir_pc(o_redir_pc),
    .i_redir_ready(i_redir_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // One entry per future cycle of a sequence; a redirect entry persists until ready.
  typedef struct {
    logic        ep, ca, st, rd;
    logic [31:0] epd, cad, std, rdpc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mepc, m_mcause, m_mstatus, m_mtvec;
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mstatus_after_trap(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_1888) | 32'h0000_1800;
    if (s[3]) r = r | 32'h80;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_after_mret(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_0008) | 32'h0000_1880;
    if (s[7]) r = r | 32'h8;
    return r;
  endfunction

  task automatic sched_trap(input logic [31:0] epc, input logic [31:0] cause, input bit irq);
    exp_t e;
    logic [31:0] tgt;
    e = '{default: '0};
    e.ep = 1; e.ca = 1; e.epd = epc; e.cad = cause;
    q.push_back(e);
    e = '{default: '0};
    e.st = 1; e.std = mstatus_after_trap(m_mstatus);
    q.push_back(e);
    tgt = m_mtvec & 32'hFFFF_FFFC;
    if (irq && m_mtvec[1:0] == 2'b01) tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
    e = '{default: '0};
    e.rd = 1; e.rdpc = tgt;
    q.push_back(e);
  endtask

  task automatic sched_mret();
    exp_t e;
    e = '{default: '0};
    e.st = 1; e.std = mstatus_after_mret(m_mstatus);
    q.push_back(e);
    e = '{default: '0};
    e.rd = 1; e.rdpc = m_mepc;
    q.push_back(e);
  endtask

  // Compare all outputs against the model, then advance the model by this cycle's inputs.
  task automatic compare_and_advance();
    exp_t e;
    bit   busy_e;
    if (i_rst) q.delete();
    e = '{default: '0};
    busy_e = (q.size() != 0);
    if (busy_e) e = q[0];
    chk("busy",         32'(o_busy),        32'(busy_e));
    chk("mepc_wen",     32'(o_mepc_wen),    32'(e.ep));
    chk("mepc_wdata",   o_mepc_wdata,       e.ep ? e.epd : 32'h0);
    chk("mcause_wen",   32'(o_mcause_wen),  32'(e.ca));
    chk("mcause_wdata", o_mcause_wdata,     e.ca ? e.cad : 32'h0);
    chk("mstatus_wen",  32'(o_mstatus_wen), 32'(e.st));
    chk("mstatus_wdata",o_mstatus_wdata,    e.st ? e.std : 32'h0);
    chk("redir_valid",  32'(o_redir_valid), 32'(e.rd));
    chk("redir_pc",     o_redir_pc,         e.rd ? e.rdpc : 32'h0);
    if (!i_rst) begin
      if (busy_e) begin
        if (!e.rd || i_redir_ready) begin
          if (e.ep) m_mepc = e.epd;
          if (e.ca) m_mcause = e.cad;
          if (e.st) m_mstatus = e.std;
          void'(q.pop_front());
        end
      end else if (i_commit_valid) begin
        if (i_ecall)                     sched_trap(i_commit_pc, 32'd11, 1'b0);
        else if (i_mret)                 sched_mret();
        else if (i_irq && m_mstatus[3])  sched_trap(i_commit_npc, 32'h8000_0007, 1'b1);
      end
    end
  endtask

  task automatic step(input bit rst, input bit cv, input logic [31:0] pc, input logic [31:0] npc,
                      input bit ec, input bit mr, input bit irq, input bit rdy);
    @(posedge i_clk);
    #1;
    i_rst = rst; i_commit_valid = cv; i_commit_pc = pc; i_commit_npc = npc;
    i_ecall = ec; i_mret = mr; i_irq = irq; i_redir_ready = rdy;
    i_mtvec = m_mtvec; i_mstatus = m_mstatus; i_mepc = m_mepc;
    @(negedge i_clk);
    compare_and_advance();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, rdy);
  endtask

  initial begin
    m_mepc = 0; m_mcause = 0; m_mstatus = 0; m_mtvec = 0;
    i_rst = 1; i_commit_valid = 0; i_commit_pc = 0; i_commit_npc = 0;
    i_ecall = 0; i_mret = 0; i_irq = 0; i_redir_ready = 0;
    i_mtvec = 0; i_mstatus = 0; i_mepc = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    step(1, 1, 32'h10, 32'h14, 1, 0, 0, 0);
    idle(0);
    chk("post_reset_busy", 32'(o_busy), 32'h0);

    // ecall, direct mtvec
    m_mtvec = 32'h8000_0100; m_mstatus = 32'h8;
    step(0, 1, 32'h8000_0010, 32'h8000_0014, 1, 0, 0, 0);
    idle(0);
    chk("t1_mepc", o_mepc_wdata, 32'h8000_0010);
    chk("t1_mcause", o_mcause_wdata, 32'd11);
    idle(0);
    chk("t1_mstatus", o_mstatus_wdata, 32'h0000_1880);
    idle(1);
    chk("t1_redir_pc", o_redir_pc, 32'h8000_0100);
    idle(0);
    chk("t1_busy_low", 32'(o_busy), 32'h0);

    // timer interrupt, vectored mtvec
    m_mtvec = 32'h8000_0101; m_mstatus = 32'h8;
    step(0, 1, 32'h8000_0020, 32'h8000_0024, 0, 0, 1, 0);
    idle(0);
    chk("t2_mepc", o_mepc_wdata, 32'h8000_0024);
    chk("t2_mcause", o_mcause_wdata, 32'h8000_0007);
    idle(0);
    idle(1);
    chk("t2_redir_pc", o_redir_pc, 32'h8000_011C);

    // masked interrupt
    m_mstatus = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h8000_0200 + 32'(i * 4), 32'h8000_0204 + 32'(i * 4), 0, 0, 1, 1);
      chk("t3_busy", 32'(o_busy), 32'h0);
    end
    idle(0);
    chk("t3_no_wen", 32'(o_mepc_wen | o_mcause_wen | o_mstatus_wen | o_redir_valid), 32'h0);

    // mret
    m_mepc = 32'h8000_0014; m_mstatus = 32'h1880;
    step(0, 1, 32'h8000_0300, 32'h8000_0304, 0, 1, 0, 0);
    idle(0);
    chk("t4_mstatus", o_mstatus_wdata, 32'h0000_1888);
    chk("t4_no_mepc", 32'(o_mepc_wen | o_mcause_wen), 32'h0);
    idle(1);
    chk("t4_redir_pc", o_redir_pc, 32'h8000_0014);

    // ecall and irq together; IFU back-pressure; new commit ignored while busy
    m_mtvec = 32'h8000_0100; m_mstatus = 32'h8;
    step(0, 1, 32'h8000_0030, 32'h8000_0034, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_mcause", o_mcause_wdata, 32'd11);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h8000_0400, 32'h8000_0404, 1, 0, 1, 0);
      chk("t5_hold_valid", 32'(o_redir_valid), 32'h1);
      chk("t5_hold_pc", o_redir_pc, 32'h8000_0100);
    end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    m_mstatus = m_mstatus | 32'h8;
    step(0, 1, 32'h8000_0040, 32'h8000_0044, 0, 0, 1, 0);
    idle(0);
    chk("t5_irq_taken", o_mcause_wdata, 32'h8000_0007);
    idle(0);
    idle(1);

    // reset in TRAP_STAT
    m_mstatus = 32'h8;
    step(0, 1, 32'h8000_0050, 32'h8000_0054, 1, 0, 0, 0);
    idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_outputs_zero", 32'(o_mstatus_wen | o_redir_valid | o_busy | o_mepc_wen), 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t6_no_write", 32'(o_mstatus_wen | o_busy), 32'h0);
    end

    // randomized closed-loop traffic
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
        m_mstatus = $urandom();
        m_mtvec   = $urandom();
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), $urandom(), $urandom(),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 4) < 2), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
